sr_latch_driver: RTL

//   Drive end of the S/R latch interface: turns set/reset level requests into clean S and R pulses.

---
 rtl/sr_pkg.sv | 9 +
 rtl/sr_latch_driver.sv | 95 +++++++++
 2 files changed

// File: rtl/sr_pkg.sv
// sr_pkg: shared FSM state type and latch level encodings for the S/R latch driver.
package sr_pkg;

    typedef enum logic [1:0] {IDLE, PULSE, GUARD} state_e;

    localparam logic SR_SET   = 1'b1;
    localparam logic SR_RESET = 1'b0;

endpackage

// File: rtl/sr_latch_driver.sv
// sr_latch_driver: turns set/reset level requests into fixed-width, never-overlapping S/R pulses
// followed by a guard gap, skipping pulses that would not change the shadowed latch state.
module sr_latch_driver
    import sr_pkg::*;
#(
    parameter int PULSE_W = 2,
    parameter int GUARD_W = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_valid,
    output logic req_ready,
    input  logic req_level,
    input  logic req_force,
    output logic S,
    output logic R,
    output logic busy,
    output logic done,
    output logic shadow_q,
    output logic shadow_valid
);

    localparam int CW = $clog2((PULSE_W > GUARD_W ? PULSE_W : GUARD_W) + 1);

    state_e          state_q;
    logic [CW-1:0]   cnt_q;
    logic            level_q;
    logic            s_q;
    logic            r_q;
    logic            done_q;
    logic            shadow_valid_q;
    logic            accept;
    logic            skip;

    assign accept = req_valid & (state_q == IDLE);
    // A request matching the known latch state is a no-op unless a refresh is forced.
    assign skip   = accept & shadow_valid_q & (shadow_q == req_level) & ~req_force;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            level_q        <= SR_RESET;
            s_q            <= 1'b0;
            r_q            <= 1'b0;
            done_q         <= 1'b0;
            shadow_q       <= 1'b0;
            shadow_valid_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (skip) begin
                        done_q <= 1'b1;
                    end else if (accept) begin
                        state_q <= PULSE;
                        cnt_q   <= CW'(PULSE_W - 1);
                        level_q <= req_level;
                        s_q     <= (req_level == SR_SET);
                        r_q     <= (req_level == SR_RESET);
                    end
                end
                PULSE: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        s_q            <= 1'b0;
                        r_q            <= 1'b0;
                        shadow_q       <= level_q;
                        shadow_valid_q <= 1'b1;
                        cnt_q          <= CW'(GUARD_W - 1);
                        state_q        <= GUARD;
                    end
                end
                GUARD: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign S            = s_q;
    assign R            = r_q;
    assign busy         = (state_q != IDLE);
    assign req_ready    = (state_q == IDLE);
    assign done         = done_q;
    assign shadow_valid = shadow_valid_q;

endmodule
